local_op_sequencer: RTL and testbench
=====================================

# local_op_sequencer

Nibble-serial front/back end for the local map-algebra operator stage: collects one transaction of four 4-bit operands (A, B, C, opcode D) from a valid/ready input stream, and holds them stable on registered outputs that drive the combinational local-op datapath. It then captures that datapath's M/N results and streams them out as two nibbles over a valid/ready output interface. It sits between the pin-level I/O and the local-op stage inside the tinyspu top.

## Interface
- STICKY_OP, default 0: when 1, a transaction carries only A, B, C (3 nibbles) and the opcode comes from a register written through cfg_we/cfg_d; when 0, a transaction carries 4 nibbles, in the order A, B, C, D.
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous flush; aborts any transaction in flight.
- din  in  4  input nibble.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  sequencer accepts din this cycle.
- cfg_we  in  1  write cfg_d into the sticky opcode register. Used only when STICKY_OP=1; ignored otherwise.
- cfg_d  in  4  sticky opcode value: [3:2] = op1, [1:0] = op2.
- op_a, op_b, op_c, op_d  out  4 each  registered operands to the local-op stage.
- op_m, op_n  in  4 each  combinational results returned by the local-op stage.
- dout  out  4  output nibble.
- dout_valid  out  1  dout is valid this cycle.
- dout_ready  in  1  downstream accepts dout this cycle.
- busy  out  1  high in every state except LOAD with idx=0.

## Operation
- The FSM has four states:
  - LOAD: holds a 2-bit index idx.
  - EXEC: lasts one cycle.
  - OUT_M.
  - OUT_N.
- LOAD:
  - din_ready=1.
  - An accept (din_valid & din_ready) writes din into the operand register selected by idx (0=A, 1=B, 2=C, 3=D), then increments idx.
  - The accept at the last index goes to EXEC and resets idx to 0. The last index is 3, or 2 when STICKY_OP=1.
- STICKY_OP=1:
  - op_d is driven from the sticky register.
  - A cfg_we write takes effect on the next edge in any state.
  - EXEC samples whatever op_m/op_n the local op produces that cycle.
- EXEC:
  - din_ready=0.
  - Capture op_m into res_m and op_n into res_n.
  - Go to OUT_M.
- OUT_M: dout=res_m, dout_valid=1. If dout_ready, go to OUT_N; otherwise hold.
- OUT_N: dout=res_n, dout_valid=1. If dout_ready, go to LOAD with idx=0; otherwise hold.
- When dout_valid=0, dout=0.
- Operand registers hold their values until overwritten by the next transaction, so op_* never glitch during EXEC or output.
- This block performs no arithmetic. Results are exactly the 4-bit op_m/op_n; truncation is the local op's responsibility.
- din_ready=0 outside LOAD. There is no overlap between consecutive transactions.

## Timing
- Reset (rst_n=0 at an edge) puts the block in state LOAD with idx=0. Output values:
  - din_ready=1.
  - dout_valid=0, dout=0.
  - op_a, op_b, op_c, op_d = 0 (the sticky register is also 0).
  - busy=0.
  - res_m, res_n = 0.
- Reset mid-transaction discards all partial operands.
- clear=1 at an edge acts like reset, except that when STICKY_OP=1 the sticky opcode register is kept. clear takes priority over any simultaneous din or dout accept.
- rst_n has priority over clear.
- Latency: if the last operand is accepted at edge t, then:
  - op_* are stable from t.
  - EXEC occupies cycle t..t+1.
  - dout_valid=1 with M from edge t+1.
  - N follows one cycle after M is accepted.
- Minimum period with din_valid and dout_ready held high:
  - STICKY_OP=0: 7 cycles per transaction (4 load, 1 exec, 2 out).
  - STICKY_OP=1: 6 cycles per transaction.
- Backpressure: dout and dout_valid stay stable while dout_ready=0, for any number of cycles.
- din_valid gaps in LOAD stall idx with no state loss.
- Values presented on din while din_ready=0 are ignored and never consumed.

## Test plan
- STICKY_OP=0; send A=3, B=5, C=2, D=4'b1011 (op1 add, op2 mul) with no stalls -> dout M=8, then N=0 (16 truncated); second din accepted 7 cycles after the first.
- Send A=15, B=15, C=1, D=4'b1110 -> M=1 (225 truncated), N=2 (226 truncated). Verify op_a..op_d are held constant from the last accept until the N accept.
- Send A=4'hA, B=4'h5, C=3, D=4'b0100 with dout_ready low for 5 cycles at OUT_M and 3 cycles at OUT_N -> M=4'hF and N=3, each held stable throughout its stall; din_ready=0 for the whole stall.
- Random din_valid gaps during LOAD, then assert clear after 2 nibbles -> returns to idle (busy=0, op_*=0, dout_valid=0). The next 4 nibbles form a fresh, correct transaction.
- STICKY_OP=1: cfg_d=4'b0010 (op1 AND, op2 add), then send 3 nibbles A=6, B=3, C=5 -> M=2, N=7; period 6 cycles. A cfg write during OUT_M does not alter the results being output.
- Assert rst_n=0 during OUT_N while dout_ready=0 -> next cycle dout_valid=0, dout=0, din_ready=1, all outputs at their reset values.

Source files
------------

// File: rtl/local_op_sequencer_if.sv
// Nibble stream bundle between the pin-level I/O and the local-op sequencer:
// operand nibbles in, result nibbles out, each with a valid/ready handshake.
interface local_op_sequencer_if;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/local_op_sequencer.sv
// Collects A/B/C(/D) operand nibbles, holds them for the combinational local-op
// stage, captures its M/N results and streams them back out as two nibbles.
module local_op_sequencer #(
    parameter bit STICKY_OP = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    local_op_sequencer_if.slave  io,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_d,
    output logic [3:0]           op_a,
    output logic [3:0]           op_b,
    output logic [3:0]           op_c,
    output logic [3:0]           op_d,
    input  logic [3:0]           op_m,
    input  logic [3:0]           op_n,
    output logic                 busy
);

    typedef enum logic [1:0] {LOAD, EXEC, OUT_M, OUT_N} state_t;

    localparam logic [1:0] LAST_IDX = STICKY_OP ? 2'd2 : 2'd3;

    state_t     state, next_state;
    logic [1:0] idx, next_idx;
    logic [3:0] reg_a, reg_b, reg_c, reg_d;
    logic [3:0] sticky;
    logic [3:0] res_m, res_n;
    logic       accept;
    logic       din_ready;
    logic       dout_valid;
    logic [3:0] dout;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= LOAD;
            idx   <= 2'd0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout       = 4'd0;
        accept     = 1'b0;
        case (state)
            LOAD: begin
                din_ready = 1'b1;
                if (io.din_valid) begin
                    accept = 1'b1;
                    if (idx == LAST_IDX) begin
                        next_state = EXEC;
                        next_idx   = 2'd0;
                    end else begin
                        next_idx = idx + 2'd1;
                    end
                end
            end
            EXEC: begin
                next_state = OUT_M;
            end
            OUT_M: begin
                dout_valid = 1'b1;
                dout       = res_m;
                if (io.dout_ready) next_state = OUT_N;
            end
            OUT_N: begin
                dout_valid = 1'b1;
                dout       = res_n;
                if (io.dout_ready) next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    // Operands only change on an accept, so the local op sees stable inputs
    // through EXEC and both output beats.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            reg_a <= 4'd0;
            reg_b <= 4'd0;
            reg_c <= 4'd0;
            reg_d <= 4'd0;
            res_m <= 4'd0;
            res_n <= 4'd0;
        end else begin
            if (accept) begin
                case (idx)
                    2'd0: reg_a <= io.din;
                    2'd1: reg_b <= io.din;
                    2'd2: reg_c <= io.din;
                    default: reg_d <= io.din;
                endcase
            end
            if (state == EXEC) begin
                res_m <= op_m;
                res_n <= op_n;
            end
        end
    end

    // Survives clear; only a full reset wipes the sticky opcode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky <= 4'd0;
        end else if (cfg_we) begin
            sticky <= cfg_d;
        end
    end

    assign op_a = reg_a;
    assign op_b = reg_b;
    assign op_c = reg_c;
    assign op_d = STICKY_OP ? sticky : reg_d;

    assign busy = !((state == LOAD) && (idx == 2'd0));

    assign io.din_ready  = din_ready;
    assign io.dout_valid = dout_valid;
    assign io.dout       = dout;

endmodule

// File: tb/tb_local_op_sequencer.sv
// Directed bench for local_op_sequencer: one 4-nibble and one sticky-opcode
// instance, each driving a behavioural local-op model.
module tb_local_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n, clear, sel, din_valid, dout_ready, cfg_we;
    logic [3:0] din, cfg_d;
    logic       clear0, clear1, cfg_we_tie;
    logic [3:0] cfg_d_tie;

    local_op_sequencer_if bus0();
    local_op_sequencer_if bus1();

    // sel steers the shared stimulus to exactly one instance at a time.
    assign bus0.din        = din;
    assign bus0.din_valid  = din_valid & ~sel;
    assign bus0.dout_ready = dout_ready & ~sel;
    assign bus1.din        = din;
    assign bus1.din_valid  = din_valid & sel;
    assign bus1.dout_ready = dout_ready & sel;
    assign clear0          = clear & ~sel;
    assign clear1          = clear & sel;
    assign cfg_we_tie      = 1'b1;
    assign cfg_d_tie       = 4'hF;

    logic [3:0] op_a0, op_b0, op_c0, op_d0, m0, n0;
    logic [3:0] op_a1, op_b1, op_c1, op_d1, m1, n1;
    logic       busy0, busy1;

    function automatic logic [3:0] alu(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = x * y;
        case (op)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x + y;
            default: return p[3:0];
        endcase
    endfunction

    assign m0 = alu(op_d0[3:2], op_a0, op_b0);
    assign n0 = alu(op_d0[1:0], m0, op_c0);
    assign m1 = alu(op_d1[3:2], op_a1, op_b1);
    assign n1 = alu(op_d1[1:0], m1, op_c1);

    local_op_sequencer #(.STICKY_OP(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear0), .io(bus0),
        .cfg_we(cfg_we_tie), .cfg_d(cfg_d_tie),
        .op_a(op_a0), .op_b(op_b0), .op_c(op_c0), .op_d(op_d0),
        .op_m(m0), .op_n(n0), .busy(busy0)
    );

    local_op_sequencer #(.STICKY_OP(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .io(bus1),
        .cfg_we(cfg_we), .cfg_d(cfg_d),
        .op_a(op_a1), .op_b(op_b1), .op_c(op_c1), .op_d(op_d1),
        .op_m(m1), .op_n(n1), .busy(busy1)
    );

    logic        obs_din_ready, obs_dout_valid, obs_busy;
    logic [3:0]  obs_dout;
    logic [15:0] obs_ops;
    assign obs_din_ready  = sel ? bus1.din_ready  : bus0.din_ready;
    assign obs_dout_valid = sel ? bus1.dout_valid : bus0.dout_valid;
    assign obs_dout       = sel ? bus1.dout       : bus0.dout;
    assign obs_busy       = sel ? busy1 : busy0;
    assign obs_ops        = sel ? {op_a1, op_b1, op_c1, op_d1} : {op_a0, op_b0, op_c0, op_d0};

    int checks = 0;
    int errors = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Feeds count nibbles (MSB first) with din_valid held high; records the
    // cycle before the first and last accepting edges.
    task automatic applyStimulus(input logic [15:0] vec, input int count, output int first_acc, output int last_acc);
        int k;
        int guard;
        k = 0;
        guard = 0;
        first_acc = -1;
        last_acc = -1;
        while (k < count && guard < 50) begin
            din = vec[15 - 4*k -: 4];
            din_valid = 1'b1;
            if (obs_din_ready) begin
                if (k == 0) first_acc = cyc;
                last_acc = cyc;
                k++;
            end
            cycle();
            guard++;
        end
        din_valid = 1'b0;
        if (k < count) checkOutput("load_timeout", 16'(k), 16'(count));
    endtask

    task automatic collectResult(input logic [15:0] exp_ops, output logic [3:0] m, output logic [3:0] n, output int m_cyc);
        int got;
        int guard;
        got = 0;
        guard = 0;
        m = 4'd0;
        n = 4'd0;
        m_cyc = -1;
        dout_ready = 1'b1;
        while (got < 2 && guard < 20) begin
            checkOutput("ops_hold", obs_ops, exp_ops);
            if (obs_dout_valid) begin
                if (got == 0) begin
                    m = obs_dout;
                    m_cyc = cyc;
                end else begin
                    n = obs_dout;
                end
                got++;
            end
            cycle();
            guard++;
        end
        if (got < 2) checkOutput("out_timeout", 16'(got), 16'd2);
    endtask

    int f0, l0, f1, l1, mc, junk;
    logic [3:0] m, n;

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        sel = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        cfg_we = 1'b0;
        din = 4'd0;
        cfg_d = 4'd0;
        cycle();
        cycle();
        checkOutput("rst_din_ready", obs_din_ready, 1);
        checkOutput("rst_dout_valid", obs_dout_valid, 0);
        checkOutput("rst_dout", obs_dout, 0);
        checkOutput("rst_busy", obs_busy, 0);
        checkOutput("rst_ops", obs_ops, 16'h0000);
        rst_n = 1'b1;
        cycle();
        checkOutput("cfg_ignored_ops", obs_ops, 16'h0000);

        $display("[TB] back-to-back transactions, 4-nibble mode");
        dout_ready = 1'b1;
        applyStimulus(16'h352B, 4, f0, l0);
        collectResult(16'h352B, m, n, mc);
        checkOutput("t1_m", m, 4'h8);
        checkOutput("t1_n", n, 4'h0);
        checkOutput("t1_m_latency", 16'(mc - l0), 16'd2);
        applyStimulus(16'hFF1E, 4, f1, l1);
        checkOutput("period_4nib", 16'(f1 - f0), 16'd7);
        collectResult(16'hFF1E, m, n, mc);
        checkOutput("t2_m", m, 4'h1);
        checkOutput("t2_n", n, 4'h2);

        $display("[TB] output backpressure");
        dout_ready = 1'b0;
        applyStimulus(16'hA534, 4, f0, l0);
        din = 4'h9;
        din_valid = 1'b1;
        checkOutput("exec_din_ready", obs_din_ready, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_m_valid", obs_dout_valid, 1);
            checkOutput("stall_m", obs_dout, 4'hF);
            checkOutput("stall_m_din_ready", obs_din_ready, 0);
            cycle();
        end
        dout_ready = 1'b1;
        checkOutput("accept_m", obs_dout, 4'hF);
        cycle();
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_n_valid", obs_dout_valid, 1);
            checkOutput("stall_n", obs_dout, 4'h3);
            checkOutput("stall_n_din_ready", obs_din_ready, 0);
            cycle();
        end
        dout_ready = 1'b1;
        checkOutput("accept_n", obs_dout, 4'h3);
        cycle();
        din_valid = 1'b0;
        dout_ready = 1'b0;
        checkOutput("t3_idle_valid", obs_dout_valid, 0);
        checkOutput("t3_idle_dout", obs_dout, 0);
        checkOutput("t3_idle_busy", obs_busy, 0);
        checkOutput("t3_junk_ignored", obs_ops, 16'hA534);

        $display("[TB] load gaps then clear");
        for (int g = 0; g < 2; g++) begin
            din_valid = 1'b0;
            repeat ($urandom_range(1, 3)) cycle();
            din = (g == 0) ? 4'h7 : 4'h9;
            din_valid = 1'b1;
            checkOutput("gap_din_ready", obs_din_ready, 1);
            cycle();
        end
        din_valid = 1'b0;
        repeat ($urandom_range(1, 3)) cycle();
        checkOutput("partial_busy", obs_busy, 1);
        checkOutput("partial_ops", obs_ops, 16'h7934);
        clear = 1'b1;
        din = 4'h5;
        din_valid = 1'b1;
        cycle();
        clear = 1'b0;
        din_valid = 1'b0;
        checkOutput("clear_busy", obs_busy, 0);
        checkOutput("clear_ops", obs_ops, 16'h0000);
        checkOutput("clear_dout_valid", obs_dout_valid, 0);
        checkOutput("clear_din_ready", obs_din_ready, 1);
        applyStimulus(16'h2389, 4, f0, l0);
        collectResult(16'h2389, m, n, mc);
        checkOutput("t4_m", m, 4'h5);
        checkOutput("t4_n", n, 4'hD);

        $display("[TB] sticky opcode mode");
        sel = 1'b1;
        dout_ready = 1'b0;
        cfg_d = 4'b0010;
        cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
        checkOutput("sticky_op_d", obs_ops, 16'h0002);
        applyStimulus(16'h6350, 3, f0, l0);
        checkOutput("sticky_exec_ops", obs_ops, 16'h6352);
        cycle();
        checkOutput("sticky_m_valid", obs_dout_valid, 1);
        checkOutput("sticky_m", obs_dout, 4'h2);
        cfg_d = 4'b0111;
        cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
        checkOutput("cfg_in_out_m_ops", obs_ops, 16'h6357);
        checkOutput("cfg_in_out_m_dout", obs_dout, 4'h2);
        dout_ready = 1'b1;
        cycle();
        checkOutput("cfg_in_out_m_n", obs_dout, 4'h7);
        cycle();
        checkOutput("sticky_idle_valid", obs_dout_valid, 0);
        cfg_d = 4'b0010;
        cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
        applyStimulus(16'h6350, 3, f0, l0);
        collectResult(16'h6352, m, n, mc);
        applyStimulus(16'h6350, 3, f1, l1);
        checkOutput("period_3nib", 16'(f1 - f0), 16'd6);
        collectResult(16'h6352, m, n, mc);
        checkOutput("sticky_m_result", m, 4'h2);
        checkOutput("sticky_n_result", n, 4'h7);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        checkOutput("clear_keeps_sticky", obs_ops, 16'h0002);

        $display("[TB] reset during stalled N");
        sel = 1'b0;
        dout_ready = 1'b1;
        applyStimulus(16'hFF1E, 4, f0, l0);
        cycle();
        cycle();
        dout_ready = 1'b0;
        checkOutput("pre_rst_n_valid", obs_dout_valid, 1);
        checkOutput("pre_rst_n", obs_dout, 4'h2);
        rst_n = 1'b0;
        cycle();
        checkOutput("rst_mid_valid", obs_dout_valid, 0);
        checkOutput("rst_mid_dout", obs_dout, 0);
        checkOutput("rst_mid_din_ready", obs_din_ready, 1);
        checkOutput("rst_mid_busy", obs_busy, 0);
        checkOutput("rst_mid_ops", obs_ops, 16'h0000);
        rst_n = 1'b1;
        sel = 1'b1;
        junk = 0;
        checkOutput("rst_sticky_ops", obs_ops, 16'h0000);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
